mlp_stream_driver: RTL

- Initiator for mlp_block. Collects L*N tokens (E elements each) from a valid/ready stream and packs them into the flattened x bus.
- Pulses start, waits for done, and captures the flattened result.
- Replays the result as a valid/ready token stream.
- Sits between the token pipeline and the time-multiplexed MLP; no compute of its own.

---
 rtl/tva_mlp_pkg.sv | 22 ++
 rtl/mlp_stream_driver.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/tva_mlp_pkg.sv
// Shared definitions for the MLP streaming driver and mlp_block.
// Holds the driver state encoding and the token geometry helpers.
package tva_mlp_pkg;

    typedef enum logic [1:0] {
        S_FILL,
        S_START,
        S_WAIT,
        S_DRAIN
    } state_t;

    // Number of tokens in one block (sequence length times batch).
    function automatic int unsigned total_tokens(input int unsigned l, input int unsigned n);
        return l * n;
    endfunction

    // Bit width of one token slice on the flattened buses.
    function automatic int unsigned slice_width(input int unsigned e, input int unsigned dw);
        return e * dw;
    endfunction

endpackage

// File: rtl/mlp_stream_driver.sv
// Streams a block of tokens into the flattened MLP input bus, starts the MLP,
// waits for completion and replays the captured result as a token stream.
module mlp_stream_driver
    import tva_mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned L              = 8,
    parameter int unsigned N              = 1,
    parameter int unsigned E              = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH*E-1:0]        in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*E-1:0]        out_data,
    output logic                           out_last,
    output logic                           mlp_start,
    input  logic                           mlp_done,
    output logic [DATA_WIDTH*L*N*E-1:0]    mlp_x,
    input  logic [DATA_WIDTH*L*N*E-1:0]    mlp_out,
    input  logic                           err_clr,
    output logic                           err_framing,
    output logic                           err_timeout,
    output logic                           busy
);

    localparam int unsigned TOTAL = total_tokens(L, N);
    localparam int unsigned SW    = slice_width(E, DATA_WIDTH);
    localparam int unsigned IW    = $clog2(TOTAL) + 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(TOTAL - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t              state;
    logic [IW-1:0]       fill_idx;
    logic [IW-1:0]       drain_idx;
    logic [TW-1:0]       to_cnt;
    logic [SW*TOTAL-1:0] result;

    logic accept;
    logic at_last_slot;
    logic framing_evt;
    logic timeout_evt;

    assign in_ready     = (state == S_FILL);
    assign busy         = (state != S_FILL);
    assign accept       = in_valid && in_ready;
    assign at_last_slot = (fill_idx == LAST_IDX);

    // Framing error: in_last before the final slot, or missing on the final slot.
    assign framing_evt  = accept && (at_last_slot ? !in_last : in_last);
    assign timeout_evt  = (state == S_WAIT) && !mlp_done && (to_cnt == TO_LAST);

    always_comb begin
        out_data = '0;
        for (int unsigned t = 0; t < TOTAL; t++) begin
            if (drain_idx == IW'(t)) begin
                out_data = result[t*SW +: SW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FILL;
            fill_idx    <= '0;
            drain_idx   <= '0;
            to_cnt      <= '0;
            result      <= '0;
            mlp_x       <= '0;
            mlp_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            err_framing <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // A new error event in the same cycle as err_clr keeps the flag set.
            err_framing <= framing_evt || (err_framing && !err_clr);
            err_timeout <= timeout_evt || (err_timeout && !err_clr);

            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (in_last && !at_last_slot) begin
                            fill_idx <= '0;
                        end else begin
                            for (int unsigned t = 0; t < TOTAL; t++) begin
                                if (fill_idx == IW'(t)) begin
                                    mlp_x[t*SW +: SW] <= in_data;
                                end
                            end
                            if (at_last_slot) begin
                                fill_idx  <= '0;
                                mlp_start <= 1'b1;
                                state     <= S_START;
                            end else begin
                                fill_idx <= fill_idx + IW'(1);
                            end
                        end
                    end
                end

                S_START: begin
                    mlp_start <= 1'b0;
                    to_cnt    <= '0;
                    state     <= S_WAIT;
                end

                S_WAIT: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (mlp_done) begin
                        result    <= mlp_out;
                        drain_idx <= '0;
                        out_valid <= 1'b1;
                        out_last  <= (LAST_IDX == '0);
                        state     <= S_DRAIN;
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_FILL;
                    end
                end

                S_DRAIN: begin
                    if (out_ready) begin
                        if (drain_idx == LAST_IDX) begin
                            drain_idx <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= S_FILL;
                        end else begin
                            drain_idx <= drain_idx + IW'(1);
                            out_last  <= ((drain_idx + IW'(1)) == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule
